// File: rtl/inst_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_responder_pkg
// Shared constants for the instruction-fetch responder: bus widths, the zero
// word driven when no instruction is valid, chip-enable levels, default store
// size, and the address legality check.
// -----------------------------------------------------------------------------
package inst_mem_responder_pkg;

    localparam int          INST_ADDR_W       = 32;
    localparam int          INST_W            = 32;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        CHIP_DISABLE      = 1'b0;
    localparam int          INST_MEM_NUM_LOG2 = 10;

    // A fetch address is illegal when it is not word aligned or when it lies
    // above the last word of a store holding 2**depth_log2 words.
    function automatic logic addr_bad(input logic [INST_ADDR_W-1:0] pc,
                                      input int                     depth_log2);
        logic [INST_ADDR_W-1:0] hi_mask;
        hi_mask = ~((32'h1 << (depth_log2 + 2)) - 32'h1);
        return (pc[1:0] != 2'b00) || ((pc & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// -----------------------------------------------------------------------------
// inst_mem_responder_if
// Fetch bus between the PC stage (master) and the instruction store responder
// (slave), plus the preload write port used to fill the store.
//   ce, pc                         request from the PC stage
//   inst, inst_valid, addr_err     response
//   stall_req                      back-pressure to the PC stage
//   wr_en, wr_addr, wr_data        preload write port
// -----------------------------------------------------------------------------
interface inst_mem_responder_if
    import inst_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) ();

    logic                   ce;
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   inst_valid;
    logic                   stall_req;
    logic                   addr_err;
    logic                   wr_en;
    logic [DEPTH_LOG2-1:0]  wr_addr;
    logic [INST_W-1:0]      wr_data;

    modport master (
        output ce, pc, wr_en, wr_addr, wr_data,
        input  inst, inst_valid, stall_req, addr_err
    );

    modport slave (
        input  ce, pc, wr_en, wr_addr, wr_data,
        output inst, inst_valid, stall_req, addr_err
    );

endinterface

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// 2**DEPTH_LOG2 x 32 synchronous RAM, one write port and one read port.
// A read and a write to the same word on one edge return the old contents.
// The contents are deliberately not reset.
//   clk                  clock, rising edge
//   rd_en, rd_addr       read request, data appears on rd_data after the edge
//   rd_data              registered read data
//   wr_en, wr_addr, wr_data   write port, takes effect at the edge
// -----------------------------------------------------------------------------
module inst_mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] rd_data_q;

    // Both assignments are non-blocking, so a same-edge read sees the value
    // held before the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
// Responder side of the fetch interface. Accepts pc/ce from the PC stage, reads
// the addressed word from the instruction store and presents it for one cycle
// after WAIT_CYCLES (0..15) wait states. Illegal addresses return a nop with a
// one-cycle addr_err pulse.
//   clk   system clock, rising edge
//   rst   asynchronous reset, active low
//   bus   fetch bus (slave side) with the preload write port
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no request in flight; ce=1 accepts a request
//   ST_WAIT   | request accepted, counting wait states; stall_req high
//   ST_RESP   | inst/inst_valid/addr_err presented; ce=1 accepts the next one
// -----------------------------------------------------------------------------
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = INST_MEM_NUM_LOG2,
    parameter int WAIT_CYCLES = 0
) (
    input logic                 clk,
    input logic                 rst,
    inst_mem_responder_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LAST = 4'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        accept;
    logic [31:0] rd_data;

    // Requests are taken in IDLE and, back-to-back, in RESP.
    assign accept = (bus.ce == CHIP_ENABLE) &&
                    ((state_q == ST_IDLE) || (state_q == ST_RESP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_RESP;
                    cnt_d   = 4'd0;
                    err_d   = addr_bad(bus.pc, DEPTH_LOG2);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The word is read on the accept edge and held in the RAM output register
    // until the response cycle, so later writes cannot disturb it.
    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (bus.pc[DEPTH_LOG2+1:2]),
        .rd_data (rd_data),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data)
    );

    assign bus.inst_valid = (state_q == ST_RESP);
    assign bus.addr_err   = (state_q == ST_RESP) && err_q;
    assign bus.inst       = ((state_q == ST_RESP) && !err_q) ? rd_data : ZERO_WORD;

    // The accept-cycle term follows ce combinationally; gating with rst keeps
    // stall_req low while reset is held even if ce stays high.
    assign bus.stall_req  = rst && ((state_q == ST_WAIT) || (accept && HAS_WAIT));

endmodule

// File: tb/tb_inst_mem_responder.sv
`timescale 1ns/1ps
module tb_inst_mem_responder;

    localparam int DL = 10;
    localparam int NW = 1 << DL;
    localparam int W0 = 0;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_responder_if #(.DEPTH_LOG2(DL)) bus0 ();
    inst_mem_responder_if #(.DEPTH_LOG2(DL)) bus1 ();

    inst_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    inst_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));

    // Reference model: one request in flight per DUT; a request seen at cycle
    // n is accepted if n >= next_free, answered at n+W+1, and the DUT becomes
    // free again in that answer cycle.
    logic [31:0] mem [NW];
    int          wcyc [2] = '{W0, W1};
    int          m;
    int          next_free [2];
    int          last_acc  [2];
    int          exp_cyc   [2];
    logic [31:0] exp_data  [2];
    logic        exp_err   [2];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = 0;
        for (int d = 0; d < 2; d++) begin
            next_free[d] = 0;
            last_acc[d]  = -100;
            exp_cyc[d]   = -1;
            exp_data[d]  = 32'h0;
            exp_err[d]   = 1'b0;
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] pc, input logic we,
                         input logic [DL-1:0] wa, input logic [31:0] wd);
        bus0.ce = ce; bus0.pc = pc; bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd;
        bus1.ce = ce; bus1.pc = pc; bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".inst"},       0, bus0.inst, 32'h0);
        chk({tag, ".inst_valid"}, 0, 32'(bus0.inst_valid), 32'h0);
        chk({tag, ".stall_req"},  0, 32'(bus0.stall_req), 32'h0);
        chk({tag, ".addr_err"},   0, 32'(bus0.addr_err), 32'h0);
        chk({tag, ".inst"},       1, bus1.inst, 32'h0);
        chk({tag, ".inst_valid"}, 1, 32'(bus1.inst_valid), 32'h0);
        chk({tag, ".stall_req"},  1, 32'(bus1.stall_req), 32'h0);
        chk({tag, ".addr_err"},   1, 32'(bus1.addr_err), 32'h0);
    endtask

    task automatic check_outputs(input logic ce_now);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] o_inst;
            logic        o_v, o_s, o_e, acc, e_v, e_s;
            if (d == 0) begin
                o_inst = bus0.inst; o_v = bus0.inst_valid; o_s = bus0.stall_req; o_e = bus0.addr_err;
            end else begin
                o_inst = bus1.inst; o_v = bus1.inst_valid; o_s = bus1.stall_req; o_e = bus1.addr_err;
            end
            acc = ce_now && (m >= next_free[d]);
            e_v = (m == exp_cyc[d]);
            e_s = (wcyc[d] > 0) && (acc || ((m > last_acc[d]) && (m <= last_acc[d] + wcyc[d])));
            chk("inst_valid", d, 32'(o_v), 32'(e_v));
            chk("inst",       d, o_inst, e_v ? exp_data[d] : 32'h0);
            chk("addr_err",   d, 32'(o_e), 32'(e_v && exp_err[d]));
            chk("stall_req",  d, 32'(o_s), 32'(e_s));
        end
    endtask

    // One clock cycle: drive at posedge+1, check at the falling edge, update
    // the model as of the coming rising edge.
    task automatic step(input logic ce, input logic [31:0] pc, input logic we,
                        input logic [DL-1:0] wa, input logic [31:0] wd);
        drive(ce, pc, we, wa, wd);
        #4;
        check_outputs(ce);
        for (int d = 0; d < 2; d++) begin
            if (ce && (m >= next_free[d])) begin
                logic bad;
                bad          = (pc % 4 != 0) || (pc >= 32'(NW * 4));
                exp_err[d]   = bad;
                exp_data[d]  = bad ? 32'h0 : mem[pc[DL+1:2]];
                exp_cyc[d]   = m + wcyc[d] + 1;
                last_acc[d]  = m;
                next_free[d] = m + wcyc[d] + 1;
            end
        end
        if (we) mem[wa] = wd;
        @(posedge clk);
        #1;
        m++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, '0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [DL-1:0] wa;
        int r;

        drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
        model_reset();
        #1 rst = 1'b0;
        #1 check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // preload: words 0..3 fixed, the rest random
        for (int i = 0; i < NW; i++) begin
            logic [31:0] v;
            v = (i < 4) ? 32'h1111_1111 * 32'(i + 1) : $urandom();
            step(1'b0, 32'h0, 1'b1, DL'(i), v);
        end
        idle(2);

        // back-to-back fetches
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        idle(5);

        // pc moves during the wait states
        fetch(32'h8);
        fetch(32'h10); fetch(32'h14); fetch(32'h18);
        idle(5);

        // misaligned and out-of-range
        fetch(32'h0000_0006);
        idle(5);
        fetch(32'h0000_1000);
        idle(5);

        // same-edge write and read of word 2
        step(1'b1, 32'h8, 1'b1, DL'(2), 32'hDEAD_BEEF);
        idle(5);
        fetch(32'h8);
        idle(5);

        // ce toggling
        fetch(32'h4); idle(1); fetch(32'hC);
        idle(5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      rpc = $urandom();
            else if (r == 1) rpc = (32'($urandom_range(0, NW - 1)) << 2) | 32'($urandom_range(1, 3));
            else             rpc = 32'($urandom_range(0, NW - 1)) << 2;
            wa = DL'($urandom_range(0, NW - 1));
            step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 3) == 0, wa, $urandom());
        end
        idle(5);

        // reset while the 3-wait-state responder is in WAIT, ce held high
        fetch(32'h4);
        drive(1'b1, 32'h8, 1'b0, '0, 32'h0);
        #2 rst = 1'b0;
        #1 check_reset("reset_mid_wait");
        @(posedge clk);
        #1 check_reset("reset_held");
        drive(1'b0, 32'h0, 1'b0, '0, 32'h0);
        rst = 1'b1;
        model_reset();
        idle(6);
        fetch(32'hC);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
